gnn_0_example_save: RTL and testbench

//  Store engine, opposite direction of the load engine: on ap_start decodes a 96-bit save instruction.

---
 rtl/gnn_0_example_save.sv | 271 +++++++++++++++++++++++++++
 tb/tb_gnn_0_example_save.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_0_example_save.sv
// gnn_0_example_save: store engine.
// On ap_start it decodes a 96-bit save instruction. It then reads a run of
// beats from one on-chip buffer (0, 2_A or 2_B) and streams them to the AXI
// write master. ap_done is pulsed once the write master reports write_done.
// Ports:
//   kernel_clk / kernel_rst_n        clock, synchronous active-low reset
//   ap_start / ap_done               start request / one-cycle completion pulse
//   ctrl_addr_offset, ctrl_instruction  DRAM base offset and save instruction
//   dram_xfer_start_addr / _size     latched transfer descriptor for the write master
//   write_start / write_done         write master handshake
//   save_read_buffer_*_{valid,addr,data}  buffer read ports (data BUF_RD_LATENCY after valid)
//   data_tvalid/tready/tlast/tdata   AXI-stream to the write master
module gnn_0_example_save #(
    parameter int unsigned SAVE_INST_LENGTH   = 96,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned BUF_ADDR_WIDTH     = 11,
    parameter int unsigned BUF_RD_LATENCY     = 2,
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
    output logic                          write_start,
    input  logic                          write_done,
    output logic                          save_read_buffer_0_valid,
    output logic [BUF_ADDR_WIDTH-1:0]     save_read_buffer_0_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_0_data,
    output logic                          save_read_buffer_2_A_valid,
    output logic [BUF_ADDR_WIDTH-1:0]     save_read_buffer_2_A_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_2_A_data,
    output logic                          save_read_buffer_2_B_valid,
    output logic [BUF_ADDR_WIDTH-1:0]     save_read_buffer_2_B_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_2_B_data,
    output logic                          data_tvalid,
    input  logic                          data_tready,
    output logic                          data_tlast,
    output logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FIDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_START,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEL_0,
        SEL_2A,
        SEL_2B,
        SEL_NONE
    } sel_t;

    state_t state, next_state;
    sel_t   dec_sel, sel_q;

    logic [BUF_ADDR_WIDTH-1:0]     start_q;
    logic [CNT_W-1:0]              len_q;
    logic [CNT_W-1:0]              issued_cnt;
    logic [CNT_W-1:0]              cap_cnt;
    logic                          wd_seen;
    logic                          rd_strobe;
    logic [BUF_RD_LATENCY-1:0]     rd_pipe;
    logic [C_M_AXI_DATA_WIDTH-1:0] rd_data;
    logic [BUF_ADDR_WIDTH-1:0]     rd_addr_next;

    logic [C_M_AXI_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]         fifo_vld;
    logic [FIFO_DEPTH-1:0]         fifo_lst;
    logic [FCNT_W-1:0]             fifo_count;
    logic [FIDX_W-1:0]             push_idx;
    logic [OCC_W-1:0]              occ;

    logic issue, pop, push;

    // Reserved instruction bits are intentionally ignored.
    logic unused_inst;
    assign unused_inst = ^{ctrl_instruction[31:6], ctrl_instruction[47:43]};

    // The FIFO is a shift register, so the stream outputs come straight from flops.
    assign data_tdata  = fifo_mem[0];
    assign data_tvalid = fifo_vld[0];
    assign data_tlast  = fifo_lst[0];

    // State register.
    always_ff @(posedge kernel_clk) begin
        if (!kernel_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, group decode, read credit and FIFO handshakes.
    always_comb begin
        next_state   = state;
        dec_sel      = SEL_NONE;
        issue        = 1'b0;
        pop          = fifo_vld[0] & data_tready;
        push         = rd_pipe[BUF_RD_LATENCY-1];
        push_idx     = FIDX_W'(fifo_count - FCNT_W'(pop));
        rd_addr_next = start_q + BUF_ADDR_WIDTH'(issued_cnt);

        case (ctrl_instruction[5:0])
            6'b000001: dec_sel = SEL_0;
            6'b001000: dec_sel = SEL_2A;
            6'b010000: dec_sel = SEL_2B;
            default:   dec_sel = SEL_NONE;
        endcase

        // Entries that will occupy the FIFO after this edge if nothing more drains.
        occ = OCC_W'(fifo_count) + OCC_W'(rd_strobe) - OCC_W'(pop);
        for (int i = 0; i < int'(BUF_RD_LATENCY); i++) begin
            occ = occ + OCC_W'(rd_pipe[i]);
        end

        case (state)
            ST_IDLE: begin
                if (ap_start) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_sel != SEL_NONE && ctrl_instruction[63:48] != CNT_W'(0)) begin
                    next_state = ST_START;
                end else begin
                    next_state = ST_DONE;
                end
            end
            ST_START: begin
                next_state = ST_STREAM;
            end
            ST_STREAM: begin
                issue = (issued_cnt < len_q) && (occ < OCC_W'(FIFO_DEPTH));
                if (pop && fifo_lst[0]) begin
                    next_state = (wd_seen || write_done) ? ST_DONE : ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (write_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Read data from whichever buffer the current instruction targets.
    always_comb begin
        rd_data = '0;
        case (sel_q)
            SEL_0:   rd_data = save_read_buffer_0_data;
            SEL_2A:  rd_data = save_read_buffer_2_A_data;
            SEL_2B:  rd_data = save_read_buffer_2_B_data;
            default: rd_data = '0;
        endcase
    end

    // Control outputs, instruction latch and read issue.
    always_ff @(posedge kernel_clk) begin
        if (!kernel_rst_n) begin
            ap_done                    <= 1'b0;
            write_start                <= 1'b0;
            dram_xfer_start_addr       <= '0;
            dram_xfer_size_in_bytes    <= '0;
            sel_q                      <= SEL_NONE;
            start_q                    <= '0;
            len_q                      <= '0;
            issued_cnt                 <= '0;
            wd_seen                    <= 1'b0;
            rd_strobe                  <= 1'b0;
            rd_pipe                    <= '0;
            save_read_buffer_0_valid   <= 1'b0;
            save_read_buffer_0_addr    <= '0;
            save_read_buffer_2_A_valid <= 1'b0;
            save_read_buffer_2_A_addr  <= '0;
            save_read_buffer_2_B_valid <= 1'b0;
            save_read_buffer_2_B_addr  <= '0;
        end else begin
            ap_done     <= (next_state == ST_DONE);
            write_start <= (next_state == ST_START);

            if (state == ST_DECODE) begin
                sel_q                   <= dec_sel;
                start_q                 <= ctrl_instruction[32 +: BUF_ADDR_WIDTH];
                len_q                   <= ctrl_instruction[63:48];
                dram_xfer_start_addr    <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(ctrl_instruction[79:64]);
                dram_xfer_size_in_bytes <= C_XFER_SIZE_WIDTH'(ctrl_instruction[95:80]);
                issued_cnt              <= '0;
                wd_seen                 <= 1'b0;
            end

            // An early write_done is remembered until the last beat leaves.
            if (state == ST_STREAM && write_done) begin
                wd_seen <= 1'b1;
            end

            rd_strobe  <= issue;
            rd_pipe[0] <= rd_strobe;
            for (int i = 1; i < int'(BUF_RD_LATENCY); i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end

            save_read_buffer_0_valid   <= issue && (sel_q == SEL_0);
            save_read_buffer_2_A_valid <= issue && (sel_q == SEL_2A);
            save_read_buffer_2_B_valid <= issue && (sel_q == SEL_2B);
            if (issue) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
                case (sel_q)
                    SEL_0:   save_read_buffer_0_addr   <= rd_addr_next;
                    SEL_2A:  save_read_buffer_2_A_addr <= rd_addr_next;
                    SEL_2B:  save_read_buffer_2_B_addr <= rd_addr_next;
                    default: ;
                endcase
            end
        end
    end

    // Output FIFO: shifts toward the head on pop, returned data lands behind the last entry.
    always_ff @(posedge kernel_clk) begin
        if (!kernel_rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            fifo_vld   <= '0;
            fifo_lst   <= '0;
            fifo_count <= '0;
            cap_cnt    <= '0;
        end else begin
            if (state == ST_DECODE) begin
                cap_cnt <= '0;
            end
            if (pop) begin
                for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                    fifo_mem[i] <= fifo_mem[i+1];
                    fifo_vld[i] <= fifo_vld[i+1];
                    fifo_lst[i] <= fifo_lst[i+1];
                end
                fifo_vld[FIFO_DEPTH-1] <= 1'b0;
                fifo_lst[FIFO_DEPTH-1] <= 1'b0;
            end
            if (push) begin
                fifo_mem[push_idx] <= rd_data;
                fifo_vld[push_idx] <= 1'b1;
                fifo_lst[push_idx] <= (cap_cnt == len_q - CNT_W'(1));
                cap_cnt            <= cap_cnt + CNT_W'(1);
            end
            fifo_count <= fifo_count + FCNT_W'(push) - FCNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_gnn_0_example_save.sv
// Scoreboard bench for gnn_0_example_save: the buffers are modelled as random
// memories, expected beats/read addresses are queued when an instruction is
// issued, and a negedge monitor checks everything the DUT presents.
module tb_gnn_0_example_save;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ap_start;
    logic         ap_done;
    logic [63:0]  ctrl_addr_offset;
    logic [95:0]  ctrl_instruction;
    logic [63:0]  dram_xfer_start_addr;
    logic [31:0]  dram_xfer_size_in_bytes;
    logic         write_start;
    logic         write_done;
    logic         v0, va, vb;
    logic [10:0]  a0, aa, ab;
    logic [511:0] d0, da, db;
    logic         data_tvalid;
    logic         data_tready;
    logic         data_tlast;
    logic [511:0] data_tdata;

    always #5 clk = ~clk;

    gnn_0_example_save dut (
        .kernel_clk                 (clk),
        .kernel_rst_n               (rst_n),
        .ap_start                   (ap_start),
        .ap_done                    (ap_done),
        .ctrl_addr_offset           (ctrl_addr_offset),
        .ctrl_instruction           (ctrl_instruction),
        .dram_xfer_start_addr       (dram_xfer_start_addr),
        .dram_xfer_size_in_bytes    (dram_xfer_size_in_bytes),
        .write_start                (write_start),
        .write_done                 (write_done),
        .save_read_buffer_0_valid   (v0),
        .save_read_buffer_0_addr    (a0),
        .save_read_buffer_0_data    (d0),
        .save_read_buffer_2_A_valid (va),
        .save_read_buffer_2_A_addr  (aa),
        .save_read_buffer_2_A_data  (da),
        .save_read_buffer_2_B_valid (vb),
        .save_read_buffer_2_B_addr  (ab),
        .save_read_buffer_2_B_data  (db),
        .data_tvalid                (data_tvalid),
        .data_tready                (data_tready),
        .data_tlast                 (data_tlast),
        .data_tdata                 (data_tdata)
    );

    typedef struct {
        logic [511:0] d;
        logic         l;
    } beat_t;

    logic [511:0] mem [3][2048];
    logic [511:0] p1 [3];
    logic [511:0] p2 [3];

    beat_t       exp_q [$];
    logic [10:0] addr_q [$];
    int          exp_port = -1;
    logic [63:0] exp_addr;
    logic [31:0] exp_size;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tr_mode = 0;
    int ws_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int beats_seen = 0;
    int last_acc_cyc = 0;
    int reads_tot = 0;
    int acc_tot = 0;
    bit prev_stall = 1'b0;
    logic [511:0] prev_d;
    logic         prev_l;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: data appears two cycles after the read strobe, junk otherwise.
    always @(posedge clk) begin
        p1[0] <= v0 ? mem[0][a0] : {16{$urandom}};
        p1[1] <= va ? mem[1][aa] : {16{$urandom}};
        p1[2] <= vb ? mem[2][ab] : {16{$urandom}};
        p2    <= p1;
    end
    assign d0 = p2[0];
    assign da = p2[1];
    assign db = p2[2];

    // tready pattern: 0 = always ready, 1 = alternating, 2 = random.
    initial begin
        data_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       data_tready = 1'b1;
                1:       data_tready = ~data_tready;
                default: data_tready = 1'($urandom % 2);
            endcase
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [2:0]  rv;
        logic [10:0] ra [3];
        logic [10:0] ea;
        beat_t       b;
        rv = {vb, va, v0};
        ra[0] = a0; ra[1] = aa; ra[2] = ab;
        if (!rst_n) begin
            reads_tot  = 0;
            acc_tot    = 0;
            prev_stall = 1'b0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (rv[p]) begin
                    checks++;
                    if (p != exp_port || addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read: port %0d addr %h, expected port %0d", p, ra[p], exp_port);
                    end else begin
                        ea = addr_q.pop_front();
                        if (ra[p] !== ea) begin
                            errors++;
                            $display("FAIL read_addr: got %h expected %h", ra[p], ea);
                        end
                    end
                    reads_tot++;
                    checks++;
                    if (reads_tot - acc_tot > 4) begin
                        errors++;
                        $display("FAIL outstanding: got %0d expected <= 4", reads_tot - acc_tot);
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if (data_tvalid !== 1'b1 || data_tdata !== prev_d || data_tlast !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold: tvalid %b tlast %b (expected 1 %b) data %h expected %h",
                             data_tvalid, data_tlast, prev_l, data_tdata, prev_d);
                end
            end
            if (data_tvalid && data_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: data %h", data_tdata);
                end else begin
                    b = exp_q.pop_front();
                    if (data_tdata !== b.d || data_tlast !== b.l) begin
                        errors++;
                        $display("FAIL beat: got last %b data %h expected last %b data %h",
                                 data_tlast, data_tdata, b.l, b.d);
                    end
                end
                acc_tot++;
                beats_seen++;
                if (data_tlast) last_acc_cyc = cyc;
            end
            prev_stall = data_tvalid && !data_tready;
            prev_d     = data_tdata;
            prev_l     = data_tlast;
            if (write_start) begin
                ws_cnt++;
                checks++;
                if (dram_xfer_start_addr !== exp_addr || dram_xfer_size_in_bytes !== exp_size) begin
                    errors++;
                    $display("FAIL xfer_desc: got %h/%0d expected %h/%0d",
                             dram_xfer_start_addr, dram_xfer_size_in_bytes, exp_addr, exp_size);
                end
            end
            if (ap_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Issue one instruction and check its whole lifecycle.
    task automatic run_inst(input logic [5:0] grp, input logic [15:0] bstart, input logic [15:0] len,
                            input logic [15:0] dram, input logic [15:0] bytes, input logic [63:0] off,
                            input int trm, input int wdm, input bit poke);
        int    port;
        bit    ok;
        int    ws0, dn0, bs0, sc, wc, n, want_done;
        beat_t b;
        logic [10:0] a;
        case (grp)
            6'b000001: port = 0;
            6'b001000: port = 1;
            6'b010000: port = 2;
            default:   port = -1;
        endcase
        ok = (port >= 0) && (len != 16'd0);
        exp_port = ok ? port : -1;
        if (ok) begin
            for (int k = 0; k < int'(len); k++) begin
                a = 11'(bstart[10:0] + 11'(k));
                addr_q.push_back(a);
                b.d = mem[port][a];
                b.l = (k == int'(len) - 1);
                exp_q.push_back(b);
            end
        end
        exp_addr = off + 64'(dram);
        exp_size = 32'(bytes);
        tr_mode  = trm;
        ws0 = ws_cnt; dn0 = done_cnt; bs0 = beats_seen;
        ctrl_instruction = {bytes, dram, len, bstart, 26'd0, grp};
        ctrl_addr_offset = off;
        ap_start = 1'b1;
        sc = cyc;
        tick();
        ap_start = 1'b0;
        want_done = 0;
        if (!ok) begin
            n = 0;
            while (done_cnt == dn0 && n < 20) begin tick(); n++; end
            check_int("skip_done_seen", done_cnt - dn0, 1);
            check_int("skip_done_cycle", done_cyc, sc + 2);
            check_int("skip_no_write_start", ws_cnt - ws0, 0);
        end else begin
            n = 0;
            while (ws_cnt == ws0 && n < 20) begin tick(); n++; end
            check_int("write_start_seen", ws_cnt - ws0, 1);
            if (wdm == 1) begin
                tick();
                write_done = 1'b1;
                tick();
                write_done = 1'b0;
            end
            if (poke) begin
                tick();
                ap_start = 1'b1;
                tick();
                ap_start = 1'b0;
            end
            n = 0;
            while (beats_seen - bs0 < int'(len) && n < 2000) begin tick(); n++; end
            check_int("beats_count", beats_seen - bs0, int'(len));
            if (wdm == 1) begin
                want_done = last_acc_cyc + 1;
            end else begin
                repeat (3) tick();
                write_done = 1'b1;
                wc = cyc;
                tick();
                write_done = 1'b0;
                want_done = wc + 1;
            end
            n = 0;
            while (done_cnt == dn0 && n < 50) begin tick(); n++; end
            check_int("done_seen", done_cnt - dn0, 1);
            check_int("done_cycle", done_cyc, want_done);
        end
        repeat (5) tick();
        check_int("single_done", done_cnt - dn0, 1);
        check_int("single_write_start", ws_cnt - ws0, ok ? 1 : 0);
        check_int("exp_q_drained", exp_q.size(), 0);
        check_int("addr_q_drained", addr_q.size(), 0);
        exp_port = -1;
    endtask

    task automatic check_outputs_zero(input string name);
        logic [1023:0] all;
        all = {ap_done, write_start, dram_xfer_start_addr, dram_xfer_size_in_bytes,
               v0, va, vb, a0, aa, ab, data_tvalid, data_tlast, data_tdata};
        checks++;
        if (all !== '0) begin
            errors++;
            $display("FAIL %s: outputs not zero, tvalid %b ap_done %b ws %b addr %h size %0d vld %b%b%b",
                     name, data_tvalid, ap_done, write_start, dram_xfer_start_addr,
                     dram_xfer_size_in_bytes, v0, va, vb);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bs0, n;
        logic [5:0] grps [4];
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < 2048; a++)
                for (int w = 0; w < 16; w++)
                    mem[p][a][w*32 +: 32] = $urandom;
        rst_n = 1'b0;
        ap_start = 1'b0;
        write_done = 1'b0;
        ctrl_instruction = '0;
        ctrl_addr_offset = '0;
        repeat (3) tick();
        @(negedge clk);
        check_outputs_zero("reset_state");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic save from buffer 0.
        run_inst(6'b000001, 16'h0010, 16'd4, 16'h0100, 16'd256, 64'h1000, 0, 0, 1'b0);
        // Buffer 2_A with alternating back-pressure.
        run_inst(6'b001000, 16'h0123, 16'd8, 16'h0040, 16'd512, 64'h0000_0001_0000_0000, 1, 0, 1'b0);
        // Buffer 2_B with address wrap.
        run_inst(6'b010000, 16'h07FE, 16'd4, 16'hFFFF, 16'd128, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1'b0);
        // Unknown group, then zero length.
        run_inst(6'b000010, 16'h0000, 16'd4, 16'h0010, 16'd64, 64'h2000, 0, 0, 1'b0);
        run_inst(6'b000001, 16'h0005, 16'd0, 16'h0010, 16'd64, 64'h2000, 0, 0, 1'b0);
        // write_done arrives early during the stream.
        run_inst(6'b000001, 16'h0200, 16'd6, 16'h0300, 16'd384, 64'h4000, 2, 1, 1'b0);

        // Reset in the middle of an 8-beat transfer.
        exp_port = 0;
        for (int k = 0; k < 8; k++) addr_q.push_back(11'(16'h0300 + k));
        for (int k = 0; k < 8; k++) begin
            beat_t b;
            b.d = mem[0][11'(16'h0300 + k)];
            b.l = (k == 7);
            exp_q.push_back(b);
        end
        exp_addr = 64'h5000 + 64'h0010;
        exp_size = 32'd512;
        tr_mode = 1;
        bs0 = beats_seen;
        ctrl_instruction = {16'd512, 16'h0010, 16'd8, 16'h0300, 26'd0, 6'b000001};
        ctrl_addr_offset = 64'h5000;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        n = 0;
        while (beats_seen - bs0 < 2 && n < 200) begin tick(); n++; end
        check_int("pre_reset_beats", (beats_seen - bs0 >= 2) ? 1 : 0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("mid_transfer_reset");
        exp_q.delete();
        addr_q.delete();
        exp_port = -1;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        // Recovery transfer, with a stray ap_start while streaming.
        run_inst(6'b000001, 16'h0040, 16'd4, 16'h0020, 16'd256, 64'h6000, 0, 0, 1'b1);

        // Randomized instructions.
        grps[0] = 6'b000001; grps[1] = 6'b001000; grps[2] = 6'b010000; grps[3] = 6'($urandom);
        for (int t = 0; t < 14; t++) begin
            logic [5:0]  g;
            logic [15:0] l;
            grps[3] = 6'($urandom);
            g = grps[$urandom_range(0, 3)];
            l = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            run_inst(g, 16'($urandom), l, 16'($urandom), 16'($urandom), {$urandom, $urandom},
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
